// File: rtl/conv_controller.sv
// -----------------------------------------------------------------------------
// conv_controller
//
// Sequencing FSM for the convolution datapath (filter buffer, image buffer,
// image slice, PE, result write-back). A run loads the 4-word filter, the
// 16-word image window, then for every column of the window loads a 4-row
// slice, runs the 16-step MAC loop, stores the result and, every fourth
// result, writes the result register back to memory. After the last column
// the x offset advances by 4 and the next image window is loaded, until the
// final slice completes.
//
// All transitions are decided from the datapath carry-outs. A counter wraps
// on the same edge where its enable is high and its carry-out is high, so a
// loop state is left on that edge and runs for exactly the counter length.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-low reset
//   start               level request, sampled only in IDLE
//   co_*                datapath carry-outs (high at terminal count)
//   busy                high in every state except IDLE
//   done                one-cycle pulse at the end of a run
//   *_en, inc_ld,
//   rst_acc, rst_res_reg,
//   wr_file, adr_sel    datapath controls
//   mem_offset_sel[1:0] 0 = filter base, 1 = image x offset, 2 = result base
//
// Configuration macro
//   CONV_CTRL_WR_FILE_EN  when defined, wr_file is high for the DONE cycle;
//                         otherwise wr_file is tied to 0.
// -----------------------------------------------------------------------------
module conv_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       co_cntr4_filter,
    input  logic       co_cntr16_img,
    input  logic       co_row_cntr,
    input  logic       co_col_cntr,
    input  logic       co_cntr16,
    input  logic       co_cntr_reg4,
    input  logic       co_cntr43,
    input  logic       co_cntr13,
    output logic       busy,
    output logic       done,
    output logic       mem_en,
    output logic       cntr4_filter_en,
    output logic       cntr16_img_en,
    output logic       filter_wr_en,
    output logic       img_wr_en,
    output logic       row_cntr_en,
    output logic       col_cntr_en,
    output logic       cntr16_en,
    output logic       img_slice_en,
    output logic       acc_en,
    output logic       cntr_reg4_en,
    output logic       res_buffer_en,
    output logic       cntr43_en,
    output logic       cntr13_en,
    output logic       inc_en,
    output logic       inc_ld,
    output logic       rst_acc,
    output logic       rst_res_reg,
    output logic       wr_file,
    output logic       adr_sel,
    output logic [1:0] mem_offset_sel
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        INIT       = 4'd1,
        LD_FILT    = 4'd2,
        LD_IMG     = 4'd3,
        SLICE      = 4'd4,
        MAC        = 4'd5,
        STORE      = 4'd6,
        WRITE      = 4'd7,
        NEXT_COL   = 4'd8,
        NEXT_SLICE = 4'd9,
        DONE       = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    // The write counter wraps on its own; its carry-out never gates the FSM.
    logic unused_co;
    assign unused_co = co_cntr43;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only the carry-out belonging to the current state
    // is looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                state_d = LD_FILT;
            end
            LD_FILT: begin
                if (co_cntr4_filter) state_d = LD_IMG;
            end
            LD_IMG: begin
                if (co_cntr16_img) state_d = SLICE;
            end
            SLICE: begin
                if (co_row_cntr) state_d = MAC;
            end
            MAC: begin
                if (co_cntr16) state_d = STORE;
            end
            STORE: begin
                state_d = co_cntr_reg4 ? WRITE : NEXT_COL;
            end
            WRITE: begin
                state_d = NEXT_COL;
            end
            NEXT_COL: begin
                state_d = co_col_cntr ? NEXT_SLICE : SLICE;
            end
            NEXT_SLICE: begin
                state_d = co_cntr13 ? DONE : LD_IMG;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        busy            = 1'b1;
        done            = 1'b0;
        mem_en          = 1'b0;
        cntr4_filter_en = 1'b0;
        cntr16_img_en   = 1'b0;
        filter_wr_en    = 1'b0;
        img_wr_en       = 1'b0;
        row_cntr_en     = 1'b0;
        col_cntr_en     = 1'b0;
        cntr16_en       = 1'b0;
        img_slice_en    = 1'b0;
        acc_en          = 1'b0;
        cntr_reg4_en    = 1'b0;
        res_buffer_en   = 1'b0;
        cntr43_en       = 1'b0;
        cntr13_en       = 1'b0;
        inc_en          = 1'b0;
        inc_ld          = 1'b0;
        rst_acc         = 1'b0;
        rst_res_reg     = 1'b0;
        adr_sel         = 1'b0;
        mem_offset_sel  = 2'd0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            INIT: begin
                inc_ld      = 1'b1;
                rst_acc     = 1'b1;
                rst_res_reg = 1'b1;
            end
            LD_FILT: begin
                adr_sel         = 1'b0;
                mem_offset_sel  = 2'd0;
                filter_wr_en    = 1'b1;
                cntr4_filter_en = 1'b1;
            end
            LD_IMG: begin
                adr_sel        = 1'b1;
                mem_offset_sel = 2'd1;
                img_wr_en      = 1'b1;
                cntr16_img_en  = 1'b1;
            end
            SLICE: begin
                img_slice_en = 1'b1;
                row_cntr_en  = 1'b1;
            end
            MAC: begin
                acc_en    = 1'b1;
                cntr16_en = 1'b1;
            end
            STORE: begin
                res_buffer_en = 1'b1;
                cntr_reg4_en  = 1'b1;
                rst_acc       = 1'b1;
            end
            WRITE: begin
                mem_en         = 1'b1;
                mem_offset_sel = 2'd2;
                cntr43_en      = 1'b1;
                rst_res_reg    = 1'b1;
            end
            NEXT_COL: begin
                col_cntr_en = 1'b1;
            end
            NEXT_SLICE: begin
                inc_en    = 1'b1;
                cntr13_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef CONV_CTRL_WR_FILE_EN
    // Dump memory contents once per completed run.
    assign wr_file = (state_q == DONE);
`else
    assign wr_file = 1'b0;
`endif

endmodule

// File: tb/tb_conv_controller.sv
module tb_conv_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       co_cntr4_filter, co_cntr16_img, co_row_cntr, co_col_cntr;
    logic       co_cntr16, co_cntr_reg4, co_cntr43, co_cntr13;
    logic       busy, done, mem_en, cntr4_filter_en, cntr16_img_en;
    logic       filter_wr_en, img_wr_en, row_cntr_en, col_cntr_en, cntr16_en;
    logic       img_slice_en, acc_en, cntr_reg4_en, res_buffer_en, cntr43_en;
    logic       cntr13_en, inc_en, inc_ld, rst_acc, rst_res_reg, wr_file, adr_sel;
    logic [1:0] mem_offset_sel;

    int n_checks;
    int n_fail;

    conv_controller dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .co_cntr4_filter (co_cntr4_filter),
        .co_cntr16_img   (co_cntr16_img),
        .co_row_cntr     (co_row_cntr),
        .co_col_cntr     (co_col_cntr),
        .co_cntr16       (co_cntr16),
        .co_cntr_reg4    (co_cntr_reg4),
        .co_cntr43       (co_cntr43),
        .co_cntr13       (co_cntr13),
        .busy            (busy),
        .done            (done),
        .mem_en          (mem_en),
        .cntr4_filter_en (cntr4_filter_en),
        .cntr16_img_en   (cntr16_img_en),
        .filter_wr_en    (filter_wr_en),
        .img_wr_en       (img_wr_en),
        .row_cntr_en     (row_cntr_en),
        .col_cntr_en     (col_cntr_en),
        .cntr16_en       (cntr16_en),
        .img_slice_en    (img_slice_en),
        .acc_en          (acc_en),
        .cntr_reg4_en    (cntr_reg4_en),
        .res_buffer_en   (res_buffer_en),
        .cntr43_en       (cntr43_en),
        .cntr13_en       (cntr13_en),
        .inc_en          (inc_en),
        .inc_ld          (inc_ld),
        .rst_acc         (rst_acc),
        .rst_res_reg     (rst_res_reg),
        .wr_file         (wr_file),
        .adr_sel         (adr_sel),
        .mem_offset_sel  (mem_offset_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath counter models: wrap to 0 when enabled at terminal count.
    int c_filt, c_img, c_row, c_col, c_16, c_reg4, c_43, c_13;
    always @(posedge clk) begin
        if (!rst) begin
            c_filt <= 0; c_img <= 0; c_row <= 0; c_col <= 0;
            c_16 <= 0; c_reg4 <= 0; c_43 <= 0; c_13 <= 0;
        end else begin
            if (cntr4_filter_en) c_filt <= (c_filt == 3)  ? 0 : c_filt + 1;
            if (cntr16_img_en)   c_img  <= (c_img  == 15) ? 0 : c_img + 1;
            if (row_cntr_en)     c_row  <= (c_row  == 3)  ? 0 : c_row + 1;
            if (col_cntr_en)     c_col  <= (c_col  == 12) ? 0 : c_col + 1;
            if (cntr16_en)       c_16   <= (c_16   == 15) ? 0 : c_16 + 1;
            if (cntr_reg4_en)    c_reg4 <= (c_reg4 == 3)  ? 0 : c_reg4 + 1;
            if (cntr43_en)       c_43   <= (c_43   == 42) ? 0 : c_43 + 1;
            if (cntr13_en)       c_13   <= (c_13   == 12) ? 0 : c_13 + 1;
        end
    end
    assign co_cntr4_filter = (c_filt == 3);
    assign co_cntr16_img   = (c_img  == 15);
    assign co_row_cntr     = (c_row  == 3);
    assign co_col_cntr     = (c_col  == 12);
    assign co_cntr16       = (c_16   == 15);
    assign co_cntr_reg4    = (c_reg4 == 3);
    assign co_cntr43       = (c_43   == 42);
    assign co_cntr13       = (c_13   == 12);

    // Pulse counters over a whole run.
    logic mon_en;
    int   m_inc, m_mem, m_done, m_store, m_wrf_bad, m_done_idle;
    always @(negedge clk) begin
        if (mon_en) begin
            if (inc_en)        m_inc   = m_inc + 1;
            if (mem_en)        m_mem   = m_mem + 1;
            if (done)          m_done  = m_done + 1;
            if (res_buffer_en) m_store = m_store + 1;
            if (done && !busy) m_done_idle = m_done_idle + 1;
`ifdef CONV_CTRL_WR_FILE_EN
            if (wr_file !== done) m_wrf_bad = m_wrf_bad + 1;
`else
            if (wr_file !== 1'b0) m_wrf_bad = m_wrf_bad + 1;
`endif
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [26:0] all_outs();
        return {busy, done, mem_en, cntr4_filter_en, cntr16_img_en, filter_wr_en,
                img_wr_en, row_cntr_en, col_cntr_en, cntr16_en, img_slice_en, acc_en,
                cntr_reg4_en, res_buffer_en, cntr43_en, cntr13_en, inc_en, inc_ld,
                rst_acc, rst_res_reg, wr_file, adr_sel, mem_offset_sel, 3'b000};
    endfunction

    int n, good;

    initial begin
        n_checks = 0; n_fail = 0;
        mon_en = 1'b0;
        m_inc = 0; m_mem = 0; m_done = 0; m_store = 0; m_wrf_bad = 0; m_done_idle = 0;
        rst = 1'b0;
        start = 1'b1;

        // Reset held 2 cycles with start high.
        step();
        step();
        check_eq("reset_busy", busy, 0);
        check_eq("reset_outs", all_outs(), 0);

        // Release: INIT on the next edge.
        rst = 1'b1;
        mon_en = 1'b1;
        step();
        check_eq("init_inc_ld", inc_ld, 1);
        check_eq("init_rst_acc_res", {rst_acc, rst_res_reg}, 2'b11);
        check_eq("init_busy", busy, 1);
        start = 1'b0;
        step();

        // Filter load: 4 cycles, filter base, adr_sel 0.
        n = 0; good = 0;
        while (filter_wr_en && n < 100) begin
            if (mem_offset_sel == 2'd0 && adr_sel == 1'b0 && cntr4_filter_en) good++;
            n++;
            step();
        end
        check_eq("filt_cycles", n, 4);
        check_eq("filt_sel_ok", good, 4);

        // Image load: 16 cycles, adr_sel 1, x offset.
        n = 0; good = 0;
        while (img_wr_en && n < 100) begin
            if (mem_offset_sel == 2'd1 && adr_sel == 1'b1) good++;
            n++;
            step();
        end
        check_eq("img_cycles", n, 16);
        check_eq("img_sel_ok", good, 16);

        n = 0;
        while (img_slice_en && n < 100) begin n++; step(); end
        check_eq("slice_cycles", n, 4);
        n = 0;
        while (acc_en && n < 100) begin n++; step(); end
        check_eq("mac_cycles", n, 16);
        check_eq("store_res_buf", {res_buffer_en, cntr_reg4_en, rst_acc}, 3'b111);
        step();
        check_eq("first_next_col", {col_cntr_en, mem_en}, 2'b10);

        // Run until the first write; it must follow the 4th store.
        n = 0;
        while (!mem_en && n < 500) begin n++; step(); end
        check_eq("write_mem_en", mem_en, 1);
        check_eq("write_after_stores", m_store, 4);
        check_eq("write_offset_sel", mem_offset_sel, 2);
        check_eq("write_cntr43_rst_res", {cntr43_en, rst_res_reg}, 2'b11);

        // start raised mid-run is ignored, then kept high through DONE.
        start = 1'b1;
        n = 0;
        while (!done && n < 20000) begin n++; step(); end
        check_eq("done_seen", done, 1);
        check_eq("done_busy", busy, 1);
`ifdef CONV_CTRL_WR_FILE_EN
        check_eq("done_wr_file", wr_file, 1);
`else
        check_eq("done_wr_file", wr_file, 0);
`endif
        step();
        mon_en = 1'b0;
        check_eq("after_done_idle", busy, 0);
        check_eq("run_inc_pulses", m_inc, 13);
        check_eq("run_mem_pulses", m_mem, 42);
        check_eq("run_done_pulses", m_done, 1);
        check_eq("run_store_pulses", m_store, 169);
        check_eq("run_wr_file_bad", m_wrf_bad, 0);
        check_eq("run_done_no_busy", m_done_idle, 0);
        step();
        check_eq("restart_init", inc_ld, 1);
        start = 1'b0;

        // Second run: reset at MAC cycle 7.
        n = 0;
        while (!acc_en && n < 500) begin n++; step(); end
        check_eq("mac2_entered", acc_en, 1);
        for (int i = 0; i < 6; i++) step();
        check_eq("mac2_cycle7", acc_en, 1);
        rst = 1'b0;
        step();
        check_eq("midrst_acc_en", acc_en, 0);
        check_eq("midrst_outs", all_outs(), 0);
        rst = 1'b1;
        start = 1'b1;
        step();
        check_eq("rerun_init", {inc_ld, busy}, 2'b11);
        start = 1'b0;
        step();
        check_eq("rerun_ld_filt", {filter_wr_en, cntr4_filter_en}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
